// File: rtl/icache_sa_if.sv
`default_nettype none
// ============================================================================
// Module   : icache_sa_if
// Purpose  : Fetch-side and refill-side signal bundle for icache_sa.
// Revision : 1.0
// ============================================================================
interface icache_sa_if #(
   parameter int WORD_SIZE = 32
);
   logic [31:0]          addr;
   logic                 valid;
   logic                 flush;
   logic                 hit;
   logic [WORD_SIZE-1:0] data;
   logic                 stall;
   logic                 mem_read;
   logic [31:0]          mem_addr;
   logic [WORD_SIZE-1:0] mem_data;
   logic                 mem_valid;

   // master is the environment: the fetch requester plus the refill memory
   modport master (
      output addr, valid, flush, mem_data, mem_valid,
      input  hit, data, stall, mem_read, mem_addr
   );

   modport slave (
      input  addr, valid, flush, mem_data, mem_valid,
      output hit, data, stall, mem_read, mem_addr
   );
endinterface
`default_nettype wire

// File: rtl/icache_sa.sv
`default_nettype none
// ============================================================================
// Module   : icache_sa
// Purpose  : Set-associative instruction cache, zero-cycle hit, blocking line
//            refill. Define ICACHE_PERF_CNT_EN to add hit/miss counters.
// Revision : 1.0
// ============================================================================
module icache_sa #(
   parameter int WORD_SIZE      = 32,
   parameter int WORDS_PER_LINE = 4,
   parameter int NUM_SETS       = 16,
   parameter int WAYS           = 2
) (
   input  wire logic  clk,
   input  wire logic  reset,
   icache_sa_if.slave bus
`ifdef ICACHE_PERF_CNT_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);
   localparam int OFF_W  = $clog2(WORDS_PER_LINE * 4);
   localparam int WOFF_W = $clog2(WORDS_PER_LINE);
   localparam int IDX_W  = $clog2(NUM_SETS);
   localparam int TAG_W  = 32 - OFF_W - IDX_W;
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [WOFF_W-1:0] LAST_BEAT = WOFF_W'(WORDS_PER_LINE - 1);
   localparam logic [WAY_W-1:0]  LAST_WAY  = WAY_W'(WAYS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REFILL  = 2'd1,
      RESPOND = 2'd2
   } state_t;

   state_t state, state_next;

   logic [WORD_SIZE-1:0] data_mem   [WAYS][NUM_SETS][WORDS_PER_LINE];
   logic [TAG_W-1:0]     tag_mem    [WAYS][NUM_SETS];
   logic [NUM_SETS-1:0]  valid_bits [WAYS];
   logic [WAY_W-1:0]     rr_ptr     [NUM_SETS];

   // tag+index of the line being refilled; offset bits are implicitly zero
   logic [31-OFF_W:0]    line_q;
   logic [WOFF_W-1:0]    req_word;
   logic [WOFF_W-1:0]    beat;
   logic [WAY_W-1:0]     victim;
   logic                 flush_pend;

   logic [IDX_W-1:0]     req_idx;
   logic [TAG_W-1:0]     req_tag;
   logic [WOFF_W-1:0]    req_woff;
   logic [IDX_W-1:0]     ref_idx;
   logic [TAG_W-1:0]     ref_tag;

   logic                 lookup_hit;
   logic [WORD_SIZE-1:0] lookup_word;
   logic [WAY_W-1:0]     victim_sel;
   logic                 free_found;

   logic                 hit_c, stall_c, mem_read_c;
   logic [WORD_SIZE-1:0] data_c;
   logic                 start_miss, fill_done;

   assign req_idx  = bus.addr[OFF_W +: IDX_W];
   assign req_tag  = bus.addr[31 -: TAG_W];
   assign req_woff = bus.addr[2 +: WOFF_W];
   assign ref_idx  = line_q[IDX_W-1:0];
   assign ref_tag  = line_q[31-OFF_W -: TAG_W];

   // Victim defaults to the set's round-robin pointer unless a free way exists
   always_comb begin
      lookup_hit  = 1'b0;
      lookup_word = '0;
      victim_sel  = rr_ptr[req_idx];
      free_found  = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_bits[w][req_idx] && (tag_mem[w][req_idx] == req_tag)) begin
            lookup_hit  = 1'b1;
            lookup_word = data_mem[w][req_idx][req_woff];
         end
         if (!free_found && !valid_bits[w][req_idx]) begin
            victim_sel = WAY_W'(w);
            free_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      hit_c      = 1'b0;
      stall_c    = 1'b0;
      mem_read_c = 1'b0;
      data_c     = '0;
      start_miss = 1'b0;
      fill_done  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.valid) begin
               if (lookup_hit) begin
                  hit_c  = 1'b1;
                  data_c = lookup_word;
               end else begin
                  stall_c    = 1'b1;
                  start_miss = 1'b1;
                  state_next = REFILL;
               end
            end
         end
         REFILL: begin
            stall_c    = 1'b1;
            mem_read_c = 1'b1;
            if (bus.mem_valid && (beat == LAST_BEAT)) begin
               fill_done  = 1'b1;
               state_next = RESPOND;
            end
         end
         RESPOND: begin
            hit_c      = 1'b1;
            data_c     = data_mem[victim][ref_idx][req_word];
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // Reset silences every output in the same cycle it is applied
      if (reset) begin
         hit_c      = 1'b0;
         stall_c    = 1'b0;
         mem_read_c = 1'b0;
         data_c     = '0;
         start_miss = 1'b0;
         fill_done  = 1'b0;
      end
   end

   assign bus.hit      = hit_c;
   assign bus.stall    = stall_c;
   assign bus.mem_read = mem_read_c;
   assign bus.data     = data_c;
   assign bus.mem_addr = mem_read_c ? {line_q, beat, 2'b00} : 32'd0;

   always_ff @(posedge clk) begin
      if (reset) begin
         line_q     <= '0;
         req_word   <= '0;
         beat       <= '0;
         victim     <= '0;
         flush_pend <= 1'b0;
         for (int w = 0; w < WAYS; w++)     valid_bits[w] <= '0;
         for (int s = 0; s < NUM_SETS; s++) rr_ptr[s]     <= '0;
      end else begin
         if (start_miss) begin
            line_q   <= bus.addr[31:OFF_W];
            req_word <= req_woff;
            victim   <= victim_sel;
            beat     <= '0;
         end
         if ((state == REFILL) && bus.mem_valid) beat <= beat + WOFF_W'(1);
         if (fill_done) begin
            valid_bits[victim][ref_idx] <= 1'b1;
            rr_ptr[ref_idx] <= (rr_ptr[ref_idx] == LAST_WAY) ? '0 : rr_ptr[ref_idx] + WAY_W'(1);
         end
         if (bus.flush && (state != IDLE)) flush_pend <= 1'b1;
         // A flush seen mid-miss also kills the line that just completed
         if ((bus.flush && (state == IDLE)) || ((state == RESPOND) && (bus.flush || flush_pend))) begin
            for (int w = 0; w < WAYS; w++) valid_bits[w] <= '0;
            flush_pend <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && (state == REFILL) && bus.mem_valid) data_mem[victim][ref_idx][beat] <= bus.mem_data;
      if (fill_done) tag_mem[victim][ref_idx] <= ref_tag;
   end

`ifdef ICACHE_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if ((state == IDLE) && bus.valid && lookup_hit) hit_count <= hit_count + 32'd1;
         if (start_miss) miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: doc/icache_sa.md
ICACHE_SA -- requirements
Module: icache_sa

Interface
REQ-001 The block SHALL expose parameter WORD_SIZE, default 32, meaning instruction word width in bits.
REQ-002 The block SHALL expose parameter WORDS_PER_LINE, default 4, meaning words per cache line (power of 2, >=2).
REQ-003 The block SHALL expose parameter NUM_SETS, default 16, meaning sets (power of 2).
REQ-004 The block SHALL expose parameter WAYS, default 2, meaning associativity (1, 2 or 4).
REQ-005 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-006 Port reset  input  1  synchronous, active-high reset.
REQ-007 Port addr  input  32  fetch byte address; bits [1:0] ignored.
REQ-008 Port valid  input  1  fetch request qualifier.
REQ-009 Port flush  input  1  invalidate-all request, one-cycle pulse.
REQ-010 Port hit  output  1  data valid for the current request.
REQ-011 Port data  output  WORD_SIZE  fetched instruction word.
REQ-012 Port stall  output  1  high while a miss is in progress; requester holds addr/valid.
REQ-013 Port mem_read  output  1  refill beat request to memory.
REQ-014 Port mem_addr  output  32  word-aligned address of the requested beat.
REQ-015 Port mem_data  input  WORD_SIZE  refill beat data.
REQ-016 Port mem_valid  input  1  mem_data valid this cycle; accepts the current beat.

Function
REQ-017 Address split SHALL be: offset = low log2(WORDS_PER_LINE*4) bits, index = next log2(NUM_SETS) bits, tag = remaining upper bits.
REQ-018 FSM states SHALL be IDLE, REFILL, RESPOND.
REQ-019 In IDLE with valid=1 and a tag match on a valid way, hit=1 and data SHALL be driven combinationally in the same cycle (zero-cycle hit latency); stall=0.
REQ-020 In IDLE with valid=1 and no match, stall SHALL be 1 combinationally and the FSM SHALL enter REFILL next cycle, latching line base address and victim way.
REQ-021 In REFILL, mem_read=1 and mem_addr = line base + 4*beat; beat SHALL advance only on mem_valid=1; mem_valid with mem_read=0 SHALL be ignored.
REQ-022 Each accepted beat SHALL be written into the victim way; after beat WORDS_PER_LINE-1 the tag and valid bit SHALL be written and the FSM SHALL enter RESPOND.
REQ-023 RESPOND SHALL last exactly one cycle with hit=1, stall=0, data = requested word, then return to IDLE.
REQ-024 Miss latency SHALL be 1 + (cycles to collect WORDS_PER_LINE beats) + 1 cycles from request to hit.
REQ-025 Victim selection SHALL pick the lowest-index invalid way; if all valid, a per-set round-robin pointer, advanced on every refill of that set.
REQ-026 flush in IDLE SHALL clear all valid bits next cycle; flush during REFILL/RESPOND SHALL be latched and applied on return to IDLE (completed line is also invalidated).
REQ-027 hit SHALL be 0 whenever valid=0 in IDLE; data is don't-care when hit=0.
REQ-028 Round-robin pointer SHALL wrap from WAYS-1 to 0.

Reset
REQ-029 reset SHALL clear all valid bits and round-robin pointers, force IDLE and clear beat counter and pending flush.
REQ-030 During and after reset: hit=0, stall=0, mem_read=0, mem_addr=0, data=0.
REQ-031 Reset mid-REFILL SHALL abort the refill; mem_read SHALL be 0 in the cycle after reset asserts and the partial line SHALL remain invalid.

Configuration
REQ-032 Macro ICACHE_PERF_CNT_EN, when defined, SHALL add outputs hit_count and miss_count (32 bits each), incremented once per IDLE hit and once per miss entry, cleared by reset, wrapping at 2^32.
REQ-033 Without ICACHE_PERF_CNT_EN these ports and counters SHALL be absent and behaviour otherwise identical.

Verification
REQ-034 Cold fetch 0x10, memory returns 0xA0,0xA1,0xA2,0xA3 at 0x10..0x1C one beat/cycle -> mem_addr sequence 0x10,0x14,0x18,0x1C; hit=1 data=0xA0 in RESPOND.
REQ-035 Then fetch 0x18 -> same-cycle hit=1, data=0xA2, mem_read=0.
REQ-036 Fill 0x010, 0x110 (same set 1, both ways), then 0x210 -> way 0 replaced; 0x110 still hits, 0x010 misses.
REQ-037 mem_valid gaps of 3 cycles between beats -> mem_addr holds, stall stays 1, correct data returned.
REQ-038 flush pulse during refill of 0x20 -> RESPOND returns word, next fetch of 0x20 misses.
REQ-039 reset asserted at beat 2 of a refill -> mem_read=0 next cycle; refetch of that address misses.
